// File: rtl/serial_mag_comparator.sv
// -----------------------------------------------------------------------------
// serial_mag_comparator
//   Bit-serial, MSB-first unsigned magnitude comparator. Operands are captured
//   on an accepted start, then one bit pair per clock is fed through the 1-bit
//   compare cell (cmp_bit). The first differing bit decides the result; it is
//   held in sticky flags and published on less/great/eq with a one-cycle done.
//
//   Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//     Defined   : leave SHIFT on the first differing bit pair (shorter latency,
//                 identical results).
//     Undefined : fixed WIDTH-clock latency.
//
//   Ports
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     start  in   begin a comparison (accepted in IDLE only)
//     a, b   in   WIDTH-bit unsigned operands, sampled on the accepting edge
//     busy   out  high while bits are being evaluated
//     done   out  one-cycle pulse, result valid in this cycle
//     less   out  A <  B  (held until the next done)
//     great  out  A >  B
//     eq     out  A == B
// -----------------------------------------------------------------------------

// 1-bit compare cell
module cmp_bit (
   input  logic a,
   input  logic b,
   output logic less,
   output logic great,
   output logic eq
);
   assign less  = ~a &  b;
   assign great =  a & ~b;
   assign eq    = ~(a ^ b);
endmodule

module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             less,
   output logic             great,
   output logic             eq
);
   // counter must be at least one bit wide even for WIDTH=1
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             gt_r, lt_r;

   logic c_lt, c_gt, c_eq;
   logic decided, gt_nx, lt_nx, last;

   cmp_bit u_cell (
      .a     (sa[WIDTH-1]),
      .b     (sb[WIDTH-1]),
      .less  (c_lt),
      .great (c_gt),
      .eq    (c_eq)
   );

   // once a flag is set the lower bits no longer matter
   assign decided = gt_r | lt_r;
   assign gt_nx   = decided ? gt_r : c_gt;
   assign lt_nx   = decided ? lt_r : c_lt;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign last = (cnt == '0) | ~c_eq;
`else
   assign last = (cnt == '0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         cnt   <= '0;
         gt_r  <= 1'b0;
         lt_r  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         less  <= 1'b0;
         great <= 1'b0;
         eq    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  cnt   <= CW'(WIDTH - 1);
                  gt_r  <= 1'b0;
                  lt_r  <= 1'b0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               gt_r <= gt_nx;
               lt_r <= lt_nx;
               sa   <= sa << 1;
               sb   <= sb << 1;
               cnt  <= cnt - 1'b1;
               if (last) begin
                  // undecided so far -> equality rests on this last bit pair
                  less  <= lt_nx;
                  great <= gt_nx;
                  eq    <= ~decided & c_eq;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_mag_comparator.sv
module tb_serial_mag_comparator;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         busy, done, less, great, eq;

   int checks = 0;
   int errors = 0;

   // last published result, expected to hold until the next done
   logic prev_l = 1'b0, prev_g = 1'b0, prev_e = 1'b0;

   serial_mag_comparator #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .less  (less),
      .great (great),
      .eq    (eq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference latency: clocks from acceptance to done
   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int i = W - 1; i >= 0; i--)
         if (x[i] != y[i]) return W - i;
      return W;
`else
      return W;
`endif
   endfunction

   // Precondition: DUT idle, time is just after a rising edge.
   task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit keep_start);
      int n;
      int lat;
      bit seen;
      lat  = ref_lat(av, bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_accept_busy"}, busy, 1);
      if (!keep_start) start = 1'b0;
      n    = 0;
      seen = 0;
      while (n < 4 * W + 4) begin
         a = W'($urandom);
         b = W'($urandom);
         @(posedge clk); #1;
         n++;
         if (done) begin
            seen = 1;
            break;
         end
         if (!busy || less !== prev_l || great !== prev_g || eq !== prev_e)
            chk({tag, "_hold"}, {busy, less, great, eq}, {1'b1, prev_l, prev_g, prev_e});
      end
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_latency"}, n, lat);
      chk({tag, "_busy_low"}, busy, 0);
      chk({tag, "_less"}, less, av < bv);
      chk({tag, "_great"}, great, av > bv);
      chk({tag, "_eq"}, eq, av == bv);
      prev_l = av < bv;
      prev_g = av > bv;
      prev_e = av == bv;
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      // 1: reset with random inputs
      rst_n = 1'b0;
      start = 1'b1;
      a     = W'($urandom);
      b     = W'($urandom);
      #2;
      chk("rst_outputs", {busy, done, less, great, eq}, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", {busy, done, less, great, eq}, 0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_no_start", {busy, done, less, great, eq}, 0);
      end

      // 2..4: directed patterns
      run_op("eq_a5", 8'hA5, 8'hA5, 0);
      run_op("msb_diff", 8'h80, 8'h7F, 0);
      run_op("lsb_diff", 8'h12, 8'h13, 0);
      run_op("zero", 8'h00, 8'h00, 0);
      run_op("ones", 8'hFF, 8'hFE, 0);

      // 5: start held high, operands scrambled while busy, back-to-back
      run_op("hold0", 8'h3C, 8'h3D, 1);
      run_op("hold1", 8'hC0, 8'h40, 1);
      run_op("hold2", 8'h55, 8'h55, 1);
      start = 1'b0;
      @(posedge clk); #1;

      // random operations against the reference
      for (int i = 0; i < 24; i++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         run_op("rand", ra, rb, i[0]);
      end
      start = 1'b0;
      @(posedge clk); #1;

      // 6: reset mid-operation
      a     = 8'hAA;
      b     = 8'hAB;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {busy, done, less, great, eq}, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("midrst_no_done", {busy, done, less, great, eq}, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      prev_l = 1'b0;
      prev_g = 1'b0;
      prev_e = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", {busy, done, less, great, eq}, 0);
      run_op("post_rst", 8'h01, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial, MSB-first magnitude comparator for two WIDTH-bit unsigned operands.
- Captures both operands on a start handshake, then evaluates one bit pair per clock using the team's 1-bit less/great/eq compare cell.
- Folds each bit result into sticky decision flags and reports less/great/eq with a one-cycle done pulse.
- Sits directly downstream of the 1-bit compare stage: it feeds that stage one bit pair per cycle and consumes its outputs.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a comparison; accepted only in IDLE.
- a  input  WIDTH  operand A (unsigned), sampled on the accepting edge.
- b  input  WIDTH  operand B (unsigned), sampled on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result outputs are valid in this cycle.
- less  output  1  A < B.
- great  output  1  A > B.
- eq  output  1  A == B.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, any time, including mid-operation):
  - state = IDLE; busy, done, less, great, eq all = 0.
  - Internal shift registers, bit counter and sticky flags cleared.
  - Reset is asserted asynchronously and released synchronously to the design.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: load a and b into shift registers, counter = WIDTH-1, clear sticky gt_r/lt_r, go to SHIFT; busy=1 after E0.
  - start=0: stay in IDLE.
- SHIFT:
  - Each cycle, present the MSB of each shift register to the 1-bit compare cell.
  - At each edge, if neither sticky flag is set: cell great=1 sets gt_r; cell less=1 sets lt_r. Once either flag is set, it is frozen until the next accepted start.
  - Shift both registers left by 1 and decrement the counter.
  - When counter == 0 at an edge, go to DONE. SHIFT therefore lasts exactly WIDTH cycles (edges E1..E_WIDTH).
- DONE:
  - Entered at edge E_WIDTH: done=1 and busy=0 for exactly one cycle.
  - On the same edge, register less=lt_final, great=gt_final, eq=~(lt_final|gt_final), where lt_final/gt_final include the last bit's contribution.
  - Next edge: return to IDLE, done=0.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clocks after the accepting edge.
- Throughput: one comparison per WIDTH+2 cycles.
- Result outputs (less/great/eq) change only on the DONE-entry edge or reset. They hold the last result through IDLE and through the following operation until its DONE.
- Exactly one of less/great/eq is 1 after the first completed operation.
- start is ignored in SHIFT and DONE; operands may change freely while busy with no effect.
- start held high continuously: a new operation is accepted on the first edge in IDLE, one cycle after done.
- WIDTH=1: one SHIFT cycle, done one clock after acceptance.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In SHIFT, when the current bit pair differs (cell less or great = 1), go to DONE on that edge regardless of the counter.
  - Latency = WIDTH - i clocks, where i is the index of the most significant differing bit; equal operands still take WIDTH clocks.
  - Results are identical to the non-early-exit build.
- Not defined: fixed WIDTH-clock latency; no early-exit logic synthesized.

Test Plan:
1. Assert rst_n=0 with random inputs -> busy=done=less=great=eq=0; after release, start=0 keeps all outputs 0.
2. WIDTH=8, a=8'hA5, b=8'hA5, start for 1 cycle -> busy high 8 cycles; done high exactly 8 clocks after acceptance; eq=1, less=0, great=0; same result with the macro defined.
3. a=8'h80, b=8'h7F -> great=1, less=0, eq=0. Without the macro, done at 8 clocks; with SERIAL_CMP_EARLY_EXIT_EN, done at 1 clock.
4. a=8'h12, b=8'h13 (LSB differs) -> less=1, great=0, eq=0; done at 8 clocks in both builds; prior result held on the outputs until that done.
5. start held high and a/b changed every cycle while busy -> only the operands from the accepting edge are used; next acceptance on the first IDLE edge after done; results match the captured operands.
6. rst_n pulsed low 3 cycles into SHIFT -> outputs zero immediately, no done pulse; a fresh start with a=8'h01, b=8'h00 -> great=1 at 8 clocks.
